// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed little-endian byte stream, writes 32-bit words into
// instruction memory from address 0, and holds the CPU in reset until the load completes.
module imem_loader #(
  parameter int unsigned IM_DEPTH = 1024,
  parameter int unsigned ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       word_count
);

  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StWrite, StRun, StErr
  } state_e;

  state_e              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         len_q, len_d;
  logic [1:0]          byte_idx_q, byte_idx_d;
  logic [23:0]         word_q, word_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         word_count_q, word_count_d;
  logic [15:0]         len_new;
  logic                xfer;

  assign xfer    = in_valid && in_ready;
  assign len_new = {in_data, len_lo_q};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      len_lo_q     <= '0;
      len_q        <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      len_lo_q     <= len_lo_d;
      len_q        <= len_d;
      byte_idx_q   <= byte_idx_d;
      word_q       <= word_d;
      wdata_q      <= wdata_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    len_lo_d     = len_lo_q;
    len_d        = len_q;
    byte_idx_d   = byte_idx_q;
    word_d       = word_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    word_count_d = word_count_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StLenLo;
          word_count_d = '0;
        end
      end
      StLenLo: begin
        if (xfer) begin
          len_lo_d = in_data;
          state_d  = StLenHi;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_d = len_new;
          if (len_new == 16'd0) begin
            state_d = StRun;
          end else if ({16'd0, len_new} > IM_DEPTH) begin
            state_d = StErr;
          end else begin
            word_count_d = '0;
            byte_idx_d   = '0;
            state_d      = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          byte_idx_d = byte_idx_q + 2'd1;
          unique case (byte_idx_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            2'd3: begin
              // Top byte goes straight to the write register so WRITE follows immediately.
              wdata_d = {in_data, word_q};
              addr_d  = word_count_q[ADDR_W-1:0];
              state_d = StWrite;
            end
          endcase
        end
      end
      StWrite: begin
        word_count_d = word_count_q + 16'd1;
        state_d      = (word_count_q + 16'd1 == len_q) ? StRun : StData;
      end
      StRun: begin
        if (start) begin
          state_d      = StLenLo;
          word_count_d = '0;
        end
      end
      StErr: state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  assign in_ready   = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
  assign im_we      = (state_q == StWrite);
  assign im_addr    = addr_q;
  assign im_wdata   = wdata_q;
  assign cpu_rstn   = (state_q == StRun);
  assign done       = (state_q == StRun);
  assign err        = (state_q == StErr);
  assign busy       = in_ready || (state_q == StWrite);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a driver streams bytes with random gaps while a
// monitor pops expected memory writes from a scoreboard queue.
module tb_imem_loader;
  localparam int unsigned IM_DEPTH = 1024;
  localparam int unsigned ADDR_W   = 10;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data = 8'h00;
  logic              in_ready, im_we, cpu_rstn, busy, done, err;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic [15:0]       word_count;

  imem_loader #(.IM_DEPTH(IM_DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .cpu_rstn(cpu_rstn), .busy(busy), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  int          vectors = 0;
  int          miscompares = 0;
  wr_t         exp_q[$];
  logic [7:0]  stream[$];
  logic [31:0] words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every memory write must match the next scoreboard entry.
  always @(negedge clk) begin
    if (rstn === 1'b1 && im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write", im_addr,
                 im_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("im_addr", 32'(im_addr), 32'(e.addr));
        check("im_wdata", im_wdata, e.data);
        check("in_ready_during_write", 32'(in_ready), 32'd0);
        check("cpu_rstn_during_write", 32'(cpu_rstn), 32'd0);
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rstn = 1'b0;
    repeat (cycles) tick();
    rstn = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drive stream[] with random idle cycles; a byte only advances when accepted.
  task automatic send_stream(input int gap_pct);
    int idx = 0;
    int guard = 0;
    while (idx < stream.size()) begin
      bit v;
      v = ($urandom_range(99) >= gap_pct);
      in_valid = v;
      in_data  = v ? stream[idx] : 8'($urandom);
      if (v && in_ready) idx++;
      tick();
      guard++;
      if (guard > 8 * stream.size() + 200) begin
        vectors++;
        miscompares++;
        $display("FAIL stream_timeout: got %0d bytes accepted expected %0d", idx,
                 stream.size());
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Reference: length prefix, then each word LSB first; every word lands at its index.
  task automatic build_stream(input int len, input int nwords_sent, input int nbytes_cut);
    stream.delete();
    stream.push_back(8'(len));
    stream.push_back(8'(len >> 8));
    for (int i = 0; i < nwords_sent; i++) begin
      for (int b = 0; b < 4; b++) stream.push_back(8'(words[i] >> (8 * b)));
      if (nbytes_cut == 0 || 4 * (i + 1) <= nbytes_cut)
        exp_q.push_back('{addr: ADDR_W'(i), data: words[i]});
    end
    if (nbytes_cut != 0) while (stream.size() > nbytes_cut + 2) void'(stream.pop_back());
  endtask

  task automatic full_load(input string tag, input int gap_pct);
    int n = words.size();
    build_stream(n, n, 0);
    pulse_start();
    check({tag, "_cpu_rstn_after_start"}, 32'(cpu_rstn), 32'd0);
    check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
    send_stream(gap_pct);
    check({tag, "_in_write_cpu_rstn"}, 32'(cpu_rstn), 32'd0);
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cpu_rstn"}, 32'(cpu_rstn), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_word_count"}, 32'(word_count), 32'(n));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic random_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    // Reset state
    do_reset(2);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_im_we", 32'(im_we), 32'd0);
    check("rst_im_addr", 32'(im_addr), 32'd0);
    check("rst_im_wdata", im_wdata, 32'd0);
    check("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) tick();
    check("idle_ignores_valid", 32'(busy), 32'd0);
    in_valid = 1'b0;

    // Basic load without gaps, then with heavy gaps
    words = '{32'h00100513, 32'h00200593};
    full_load("basic", 0);
    do_reset(1);
    full_load("gaps", 60);

    // Zero length
    words.delete();
    build_stream(0, 0, 0);
    pulse_start();
    send_stream(30);
    check("zero_done", 32'(done), 32'd1);
    check("zero_cpu_rstn", 32'(cpu_rstn), 32'd1);
    check("zero_word_count", 32'(word_count), 32'd0);

    // Reload from RUN with a 1-word load, then DEADBEEF
    random_words(1);
    full_load("reload1", 20);
    words = '{32'hDEADBEEF};
    full_load("reload2", 20);

    // Reset mid-load after 6 payload bytes of a 2-word load
    do_reset(1);
    random_words(2);
    build_stream(2, 2, 6);
    pulse_start();
    send_stream(30);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    check("midrst_word_count", 32'(word_count), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    random_words(2);
    full_load("after_midrst", 30);

    // Overflow, including the exact boundary and random larger lengths
    for (int t = 0; t < 3; t++) begin
      int len;
      len = (t == 0) ? IM_DEPTH + 1 : IM_DEPTH + 1 + $urandom_range(65535 - IM_DEPTH - 1);
      words.delete();
      build_stream(len, 0, 0);
      pulse_start();
      send_stream(30);
      check("ovf_err", 32'(err), 32'd1);
      check("ovf_in_ready", 32'(in_ready), 32'd0);
      check("ovf_cpu_rstn", 32'(cpu_rstn), 32'd0);
      pulse_start();
      in_valid = 1'b1;
      repeat (3) tick();
      in_valid = 1'b0;
      check("ovf_sticky_err", 32'(err), 32'd1);
      check("ovf_start_ignored", 32'(busy), 32'd0);
      check("ovf_cpu_rstn_low", 32'(cpu_rstn), 32'd0);
      do_reset(1);
      check("ovf_reset_err", 32'(err), 32'd0);
      check("ovf_reset_done", 32'(done), 32'd0);
    end

    // Random loads, chained via reload from RUN
    for (int t = 0; t < 6; t++) begin
      random_words(1 + $urandom_range(6));
      full_load("random", $urandom_range(70));
    end

    // Maximum length: every address written once
    do_reset(1);
    random_words(IM_DEPTH);
    full_load("full_depth", 10);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the single-cycle CPU's instruction memory.
- Receives a length-prefixed byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes the words sequentially into instruction ROM from word address 0.
- Holds the CPU in reset until the load completes, then releases it; this replaces $readmemh preloading for on-board runs.

Parameters:
IM_DEPTH, 1024, instruction memory depth in words; maximum accepted program length
ADDR_W, 10, width of im_addr; must satisfy 2**ADDR_W >= IM_DEPTH

Ports:
clk  input  1  system clock; all state updates on rising edge
rstn  input  1  synchronous active-low reset
start  input  1  single-cycle pulse; begins a load (honoured in IDLE and RUN only)
in_valid  input  1  byte-stream valid
in_data  input  8  byte-stream data
in_ready  output  1  loader can accept a byte this cycle
im_we  output  1  instruction memory write enable, one cycle per word
im_addr  output  ADDR_W  word address for im_wdata
im_wdata  output  32  assembled instruction word
cpu_rstn  output  1  active-low reset to CPU core; 0 while not in RUN
busy  output  1  high in LEN_LO, LEN_HI, DATA, WRITE
done  output  1  high in RUN
err  output  1  sticky length-overflow flag
word_count  output  16  number of words written in the current load

Behaviour:
- Reset, sampled on the rising clk edge when rstn=0, sets:
  - state=IDLE; in_ready=0, im_we=0, im_addr=0, im_wdata=0.
  - cpu_rstn=0, busy=0, done=0, err=0, word_count=0.
  - Byte counter and length register cleared; any partial word is discarded.
- A byte transfer occurs on a cycle with in_valid=1 and in_ready=1. in_ready is registered state decode: 1 in LEN_LO, LEN_HI and DATA; 0 in all other states.
- Stream format: LEN[7:0], LEN[15:8], then 4*LEN payload bytes. Each word is sent byte0 (bits 7:0) first.
- IDLE: start=1 -> LEN_LO. Otherwise stay in IDLE.
- LEN_LO: on transfer, latch the low byte -> LEN_HI.
- LEN_HI: on transfer, latch the high byte and form LEN.
  - LEN=0 -> RUN.
  - LEN>IM_DEPTH -> ERR.
  - Otherwise clear word_count and the byte index -> DATA.
- DATA: on each transfer, place the byte in lane byte_idx of the word register and increment byte_idx (2 bits, wraps). On the transfer with byte_idx=3 -> WRITE.
- WRITE (exactly one cycle, in_ready=0):
  - im_we=1, im_addr=word_count[ADDR_W-1:0], im_wdata=assembled word.
  - Next cycle word_count increments.
  - If new word_count==LEN -> RUN, else -> DATA.
- Latency: the 4th byte is accepted at edge k; im_we is high in cycle k+1; the next byte can be accepted no earlier than cycle k+2.
- RUN: cpu_rstn=1, done=1.
  - cpu_rstn rises in the cycle after the final WRITE cycle.
  - start=1 -> LEN_LO with cpu_rstn=0 in the next cycle (reload).
  - in_valid is ignored.
- ERR: err=1, cpu_rstn=0, in_ready=0. Only rstn leaves ERR. start is ignored.
- start is ignored in LEN_LO, LEN_HI, DATA and WRITE.
- in_valid while in_ready=0: no transfer; the upstream source holds data, no byte is lost or duplicated.
- in_data is don't-care when in_valid=0.
- im_we is never high outside WRITE.
- im_addr and im_wdata hold their last values outside WRITE.
- Reset asserted mid-load (any state) returns to IDLE next edge. Memory contents already written are not cleared.
- word_count saturates naturally at LEN ≤ IM_DEPTH; it never exceeds LEN.

Test Plan:
- Basic load: rstn low 2 cycles, start, stream 02 00 13 05 10 00 93 05 20 00 -> im_we pulses at addr 0 data 0x00100513, then addr 1 data 0x00200593; cpu_rstn=1, done=1 one cycle after second write; word_count=2.
- Backpressure/gaps: same stream with in_valid toggled randomly -> identical writes; in_ready=0 during each WRITE cycle; no byte consumed while in_ready=0.
- Zero length: start, stream 00 00 -> no im_we, RUN entered the cycle after LEN_HI transfer, cpu_rstn=1.
- Overflow: start, stream 01 04 (LEN=1025 > 1024) -> ERR, err=1, in_ready=0, cpu_rstn=0 stays low; start ignored; rstn low returns to IDLE with err=0.
- Reset mid-operation: assert rstn=0 after 6 payload bytes of a 2-word load -> next edge IDLE, cpu_rstn=0, word_count=0; fresh start and full stream then loads correctly from addr 0.
- Reload from RUN: after a completed 1-word load, pulse start -> cpu_rstn=0 next cycle, new stream 01 00 EF BE AD DE writes 0xDEADBEEF at addr 0, then RUN.
